cache_control_nway: RTL and testbench

//  Control FSM for an N-way set-associative, write-back, write-allocate cache; next generation of the 2-way controller.

---
 rtl/cache_types_pkg.sv | 18 +
 rtl/cache_victim_sel.sv | 28 ++
 rtl/cache_control_nway.sv | 137 +++++++++++++
 tb/tb_cache_control_nway.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types for the N-way cache controller: FSM states and datapath mux selects.
package cache_types_pkg;
  typedef enum logic [1:0] {
    CHECK      = 2'd0,
    WRITE_BACK = 2'd1,
    FILL       = 2'd2
  } cache_state_e;

  typedef enum logic {
    PMEM_ADDR_CPU    = 1'b0,
    PMEM_ADDR_VICTIM = 1'b1
  } pmem_addr_sel_e;

  typedef enum logic {
    DATA_FROM_PMEM = 1'b0,
    DATA_FROM_CPU  = 1'b1
  } data_sel_e;
endpackage

// File: rtl/cache_victim_sel.sv
// Way selection helpers: lowest-index hit, multi-hit flag, and victim choice
// preferring the lowest invalid way before falling back to PLRU.
module cache_victim_sel #(
  parameter int NUM_WAYS  = 4,
  parameter int WAY_IDX_W = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0]  hit,
  input  logic [NUM_WAYS-1:0]  valid,
  input  logic [WAY_IDX_W-1:0] plru_victim,
  output logic                 hit_any,
  output logic [WAY_IDX_W-1:0] hit_idx,
  output logic                 multi_hit,
  output logic [WAY_IDX_W-1:0] victim
);
  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit_idx = '0;
    victim  = plru_victim;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit[i])   hit_idx = WAY_IDX_W'(i);
      if (!valid[i]) victim = WAY_IDX_W'(i);
    end
  end

  assign hit_any   = |hit;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hit = |(hit & (hit - NUM_WAYS'(1)));
endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache.
// Steers a per-way datapath; the victim is latched at miss detection and held until refill completes.
module cache_control_nway
  import cache_types_pkg::*;
#(
  parameter int NUM_WAYS  = 4,
  parameter int WAY_IDX_W = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic [NUM_WAYS-1:0]  hit,
  input  logic [NUM_WAYS-1:0]  valid,
  input  logic [NUM_WAYS-1:0]  dirty,
  input  logic [WAY_IDX_W-1:0] plru_victim,
  output logic [WAY_IDX_W-1:0] way_sel,
  output logic [NUM_WAYS-1:0]  load_data,
  output logic [NUM_WAYS-1:0]  load_tag,
  output logic [NUM_WAYS-1:0]  load_valid,
  output logic [NUM_WAYS-1:0]  load_dirty,
  output logic                 valid_in,
  output logic                 dirty_in,
  output logic                 data_sel,
  output logic                 pmem_addr_sel,
  output logic                 load_regs,
  output logic                 load_lru,
  output logic [WAY_IDX_W-1:0] lru_way,
  output logic                 multi_hit_err
);
  cache_state_e          state_q, state_d;
  logic [WAY_IDX_W-1:0]  victim_q, victim;
  logic [WAY_IDX_W-1:0]  hit_idx;
  logic                  hit_any, multi_hit, req;
  logic [NUM_WAYS-1:0]   hit_oh, vic_oh;
  logic                  unused_be;

  // Byte mask is consumed by the datapath merge only.
  assign unused_be = ^mem_byte_enable;

  assign req    = mem_read | mem_write;
  assign hit_oh = NUM_WAYS'(1) << hit_idx;
  assign vic_oh = NUM_WAYS'(1) << victim_q;

  cache_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_IDX_W(WAY_IDX_W)) u_sel (
    .hit         (hit),
    .valid       (valid),
    .plru_victim (plru_victim),
    .hit_any     (hit_any),
    .hit_idx     (hit_idx),
    .multi_hit   (multi_hit),
    .victim      (victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CHECK;
      victim_q      <= '0;
      multi_hit_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == CHECK && req && !hit_any) victim_q <= victim;
      if (state_q == CHECK && req && multi_hit) multi_hit_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CHECK:
        if (req && !hit_any)
          state_d = (valid[victim] && dirty[victim]) ? WRITE_BACK : FILL;
      WRITE_BACK: if (pmem_resp) state_d = FILL;
      FILL:       if (pmem_resp) state_d = CHECK;
      default:    state_d = CHECK;
    endcase
  end

  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = '0;
    load_data     = '0;
    load_tag      = '0;
    load_valid    = '0;
    load_dirty    = '0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    data_sel      = DATA_FROM_PMEM;
    pmem_addr_sel = PMEM_ADDR_CPU;
    load_regs     = 1'b0;
    load_lru      = 1'b0;
    lru_way       = '0;
    case (state_q)
      CHECK: begin
        if (req && hit_any) begin
          mem_resp = 1'b1;
          way_sel  = hit_idx;
          load_lru = 1'b1;
          lru_way  = hit_idx;
          if (mem_write) begin
            load_data  = hit_oh;
            load_dirty = hit_oh;
            dirty_in   = 1'b1;
            data_sel   = DATA_FROM_CPU;
          end
        end else if (req) begin
          load_regs = 1'b1;
        end
      end
      WRITE_BACK: begin
        way_sel       = victim_q;
        pmem_addr_sel = PMEM_ADDR_VICTIM;
        pmem_write    = 1'b1;
        if (pmem_resp) load_dirty = vic_oh;
      end
      FILL: begin
        way_sel   = victim_q;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data  = vic_oh;
          load_tag   = vic_oh;
          load_valid = vic_oh;
          load_dirty = vic_oh;
          valid_in   = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: 4-way instance acting against a bench-owned tag/valid/dirty set,
// plus 2-way and 8-way instances parked in FILL for the asynchronous reset check.
module tb_cache_control_nway;
  localparam int WBL = 3;
  localparam int FL  = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rd = 0, wr = 0, presp = 0;
  logic [3:0] be = 4'hf, hit = 0, valid = 0, dirty = 0;
  logic [1:0] plru = 0;
  logic       resp, pr, pw, valid_in, dirty_in, data_sel, addr_sel, load_regs, load_lru, mh_err;
  logic [1:0] way_sel, lru_way;
  logic [3:0] ld_data, ld_tag, ld_valid, ld_dirty;

  cache_control_nway #(.NUM_WAYS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .mem_byte_enable(be),
    .mem_resp(resp), .pmem_read(pr), .pmem_write(pw), .pmem_resp(presp),
    .hit(hit), .valid(valid), .dirty(dirty), .plru_victim(plru), .way_sel(way_sel),
    .load_data(ld_data), .load_tag(ld_tag), .load_valid(ld_valid), .load_dirty(ld_dirty),
    .valid_in(valid_in), .dirty_in(dirty_in), .data_sel(data_sel), .pmem_addr_sel(addr_sel),
    .load_regs(load_regs), .load_lru(load_lru), .lru_way(lru_way), .multi_hit_err(mh_err));

  logic       resp2, pr2, pw2, vi2, di2, ds2, as2, lr2, ll2, mh2;
  logic       way2, lru2;
  logic [1:0] ldd2, ldt2, ldv2, ldy2;
  cache_control_nway #(.NUM_WAYS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_read(1'b1), .mem_write(1'b0), .mem_byte_enable(4'h0),
    .mem_resp(resp2), .pmem_read(pr2), .pmem_write(pw2), .pmem_resp(1'b0),
    .hit(2'b00), .valid(2'b11), .dirty(2'b00), .plru_victim(1'b1), .way_sel(way2),
    .load_data(ldd2), .load_tag(ldt2), .load_valid(ldv2), .load_dirty(ldy2),
    .valid_in(vi2), .dirty_in(di2), .data_sel(ds2), .pmem_addr_sel(as2),
    .load_regs(lr2), .load_lru(ll2), .lru_way(lru2), .multi_hit_err(mh2));

  logic       resp8, pr8, pw8, vi8, di8, ds8, as8, lr8, ll8, mh8;
  logic [2:0] way8, lru8;
  logic [7:0] ldd8, ldt8, ldv8, ldy8;
  cache_control_nway #(.NUM_WAYS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mem_read(1'b1), .mem_write(1'b0), .mem_byte_enable(4'h0),
    .mem_resp(resp8), .pmem_read(pr8), .pmem_write(pw8), .pmem_resp(1'b0),
    .hit(8'h00), .valid(8'hff), .dirty(8'h00), .plru_victim(3'd5), .way_sel(way8),
    .load_data(ldd8), .load_tag(ldt8), .load_valid(ldv8), .load_dirty(ldy8),
    .valid_in(vi8), .dirty_in(di8), .data_sel(ds8), .pmem_addr_sel(as8),
    .load_regs(lr8), .load_lru(ll8), .lru_way(lru8), .multi_hit_err(mh8));

  int n_cmp = 0, n_bad = 0;
  // Bench-side model of one cache set.
  logic [3:0] m_valid = 0, m_dirty = 0;
  int         m_tag[4];
  int         cur_tag = -1;
  bit         force_hit = 0;
  logic [3:0] fhit = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_dp();
    for (int i = 0; i < 4; i++) hit[i] = m_valid[i] && (m_tag[i] == cur_tag);
    if (force_hit) hit = fhit;
    valid = m_valid;
    dirty = m_dirty;
  endtask

  function automatic logic [28:0] outs();
    return {resp, pr, pw, load_regs, load_lru, data_sel, dirty_in, way_sel, lru_way,
            ld_data, ld_dirty, ld_tag, ld_valid, valid_in, addr_sel};
  endfunction

  // One CPU access at transaction level: expected victim/latency derived from the set contents.
  task automatic txn(input int tag, input bit w, input int p0, input int palt, input string nm);
    int hw, v, exp_lat, lat, wcnt, rcnt;
    bit exp_wb, saw_wb, bad, done, exp_dirty;
    hw = -1;
    for (int i = 0; i < 4; i++) if (hw < 0 && m_valid[i] && m_tag[i] == tag) hw = i;
    if (hw >= 0) begin
      v = hw; exp_wb = 0; exp_lat = 1; exp_dirty = w | m_dirty[hw];
    end else begin
      v = -1;
      for (int i = 0; i < 4; i++) if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) v = p0;
      exp_wb = m_valid[v] && m_dirty[v];
      exp_lat = (exp_wb ? WBL : 0) + FL + 2;
      exp_dirty = w;
    end
    cur_tag = tag; rd = !w; wr = w; plru = 2'(p0);
    lat = 0; wcnt = 0; rcnt = 0; saw_wb = 0; bad = 0; done = 0;
    while (!done && lat < 100) begin
      presp = (wcnt == WBL - 1) || (rcnt == FL - 1);
      drive_dp();
      #1;
      lat++;
      if (pw) saw_wb = 1;
      if (pr && pw) bad = 1;
      if ((pr || pw) && (int'(way_sel) != v || addr_sel != pw)) bad = 1;
      if (ld_tag != 0 && ld_tag != 4'(1 << v)) bad = 1;
      if (resp) begin
        done = 1;
        if (int'(lru_way) != v || int'(way_sel) != v || !load_lru) bad = 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (ld_tag[i])   m_tag[i]   = cur_tag;
        if (ld_valid[i]) m_valid[i] = valid_in;
        if (ld_dirty[i]) m_dirty[i] = dirty_in;
      end
      wcnt = (pw && !presp) ? wcnt + 1 : 0;
      rcnt = (pr && !presp) ? rcnt + 1 : 0;
      @(posedge clk); @(negedge clk);
      plru = 2'(palt);
    end
    rd = 0; wr = 0; presp = 0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " writeback"}, saw_wb, exp_wb);
    chk({nm, " protocol"}, bad, 0);
    chk({nm, " line state"}, {m_valid[v], m_dirty[v], m_tag[v] == tag}, {1'b1, exp_dirty, 1'b1});
  endtask

  typedef struct {
    logic rd, wr, presp;
    logic [3:0] hit;
    logic e_resp;
    logic [1:0] e_way;
    logic [3:0] e_ld;
    logic e_wr;
  } vec_t;

  initial begin
    vec_t tbl[7];
    tbl[0] = '{1, 0, 0, 4'b0100, 1, 2'd2, 4'b0000, 0};
    tbl[1] = '{0, 1, 0, 4'b0001, 1, 2'd0, 4'b0001, 1};
    tbl[2] = '{1, 1, 0, 4'b1000, 1, 2'd3, 4'b1000, 1};
    tbl[3] = '{0, 0, 0, 4'b0010, 0, 2'd0, 4'b0000, 0};
    tbl[4] = '{0, 0, 1, 4'b0000, 0, 2'd0, 4'b0000, 0};
    tbl[5] = '{0, 1, 0, 4'b0010, 1, 2'd1, 4'b0010, 1};
    tbl[6] = '{1, 0, 1, 4'b1000, 1, 2'd3, 4'b0000, 0};
    for (int i = 0; i < 4; i++) m_tag[i] = 100 + i;

    @(negedge clk);
    drive_dp(); #1;
    chk("reset outputs", outs(), 0);
    chk("reset multi_hit_err", mh_err, 0);
    @(negedge clk); rst_n = 1;

    m_valid = 4'hf;
    force_hit = 1;
    for (int i = 0; i < 7; i++) begin
      rd = tbl[i].rd; wr = tbl[i].wr; presp = tbl[i].presp; fhit = tbl[i].hit;
      drive_dp(); #1;
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].e_resp, 3'b000, tbl[i].e_resp, tbl[i].e_wr, tbl[i].e_wr, tbl[i].e_way, tbl[i].e_way,
           tbl[i].e_ld, tbl[i].e_ld, 8'h00, 2'b00});
      @(posedge clk); @(negedge clk);
    end
    rd = 0; wr = 0; presp = 0;
    chk("no multi-hit after single hits", mh_err, 0);

    // Two ways hitting: served from the lower, error latched and sticky.
    rd = 1; fhit = 4'b0110; drive_dp(); #1;
    chk("multi-hit way_sel", {resp, way_sel}, {1'b1, 2'd1});
    @(posedge clk); @(negedge clk);
    chk("multi-hit err set", mh_err, 1);
    fhit = 4'b0001; drive_dp();
    @(posedge clk); @(negedge clk);
    rd = 0; #1;
    chk("multi-hit err sticky", mh_err, 1);
    rst_n = 0; #1;
    chk("multi-hit err reset", mh_err, 0);
    @(negedge clk); rst_n = 1;
    force_hit = 0;

    m_valid = 4'b1011; m_dirty = 0;
    txn(20, 0, 0, 3, "invalid-first fill");
    m_valid = 4'b1111; m_dirty = 4'b1000;
    txn(21, 0, 3, 1, "dirty victim frozen");
    txn(21, 1, 0, 0, "write hit after fill");
    for (int k = 0; k < 40; k++)
      txn($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", k));

    // Asynchronous reset in the middle of a fill, all three widths.
    m_dirty = 0; cur_tag = 30; rd = 1; plru = 0; drive_dp();
    repeat (3) @(negedge clk);
    #1;
    chk("pmem_read in fill 4/2/8", {pr, pr2, pr8}, 3'b111);
    rst_n = 0; #1;
    chk("pmem_read drop 4/2/8", {pr, pr2, pr8}, 3'b000);
    chk("no resp on reset 4/2/8", {resp, resp2, resp8}, 3'b000);
    chk("back in CHECK 4/2/8", {load_regs, lr2, lr8}, 3'b111);
    @(negedge clk); rd = 0; rst_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
